// File: rtl/video_timing_pkg.sv
// Shared definitions for the raster timing generator: per-axis timing record,
// standard mode constants, config field indices and the colour-bar table.
package video_timing_pkg;

    localparam int unsigned TimingW = 12;

    typedef struct packed {
        logic [TimingW-1:0] sync;
        logic [TimingW-1:0] back;
        logic [TimingW-1:0] disp;
        logic [TimingW-1:0] front;
    } video_timing_t;

    localparam video_timing_t Timing1080pH = '{sync: 12'd44, back: 12'd148,
                                               disp: 12'd1920, front: 12'd88};
    localparam video_timing_t Timing1080pV = '{sync: 12'd5, back: 12'd36,
                                               disp: 12'd1080, front: 12'd4};
    localparam video_timing_t Timing720pH  = '{sync: 12'd40, back: 12'd220,
                                               disp: 12'd1280, front: 12'd110};
    localparam video_timing_t Timing720pV  = '{sync: 12'd5, back: 12'd20,
                                               disp: 12'd720, front: 12'd5};

    // Field order inside the packed configuration word, MSB first.
    localparam int unsigned FldHSync  = 0;
    localparam int unsigned FldHBack  = 1;
    localparam int unsigned FldHDisp  = 2;
    localparam int unsigned FldHFront = 3;
    localparam int unsigned FldVSync  = 4;
    localparam int unsigned FldVBack  = 5;
    localparam int unsigned FldVDisp  = 6;
    localparam int unsigned FldVFront = 7;

    // Colour bars as {R,G,B} full-scale enables: white, yellow, cyan, green,
    // magenta, red, blue, black.
    localparam logic [2:0] BarRgb [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                          3'b101, 3'b100, 3'b001, 3'b000};

endpackage

// File: rtl/video_axis_cnt.sv
// One raster axis: position counter plus sync, active and request window decodes.
// The request window is the active window moved LEAD counts earlier.
module video_axis_cnt
    import video_timing_pkg::*;
#(
    parameter int unsigned CNT_W = 12,
    parameter int unsigned LEAD  = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] sync_i,
    input  logic [CNT_W-1:0] back_i,
    input  logic [CNT_W-1:0] disp_i,
    input  logic [CNT_W-1:0] front_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             term_o,
    output logic             sync_o,
    output logic             act_o,
    output logic             req_o,
    output logic [CNT_W-1:0] pos_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   cnt_x, total, act_start, act_end, req_start, req_end;

    assign cnt_x     = {1'b0, cnt_q};
    assign total     = {1'b0, sync_i} + {1'b0, back_i} + {1'b0, disp_i} + {1'b0, front_i};
    assign act_start = {1'b0, sync_i} + {1'b0, back_i};
    assign act_end   = act_start + {1'b0, disp_i};
    assign req_start = act_start - (CNT_W+1)'(LEAD);
    assign req_end   = act_end - (CNT_W+1)'(LEAD);

    assign cnt_o  = cnt_q;
    assign term_o = (cnt_x == total - 1'b1);
    assign sync_o = (cnt_x < {1'b0, sync_i});
    assign act_o  = (cnt_x >= act_start) && (cnt_x < act_end);
    assign req_o  = (cnt_x >= req_start) && (cnt_x < req_end);
    assign pos_o  = req_o ? CNT_W'(cnt_x - req_start) : '0;

    // Advance on enable, wrapping after the last position of the axis.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = term_o ? '0 : cnt_q + 1'b1;
        end
    end

    // Position register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator and pixel-request front end. Timing reloads are
// staged and applied on the last cycle of a frame. All outputs are registered
// from the current counter state (uniform one-cycle offset).
// Optional colour-bar test pattern: define VIDEO_TPG_EN.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned CW       = 8,
    parameter int unsigned CNT_W    = 12,
    parameter int unsigned REQ_LEAD = 1,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter logic [CNT_W-1:0] D_H_SYNC  = CNT_W'(Timing1080pH.sync),
    parameter logic [CNT_W-1:0] D_H_BACK  = CNT_W'(Timing1080pH.back),
    parameter logic [CNT_W-1:0] D_H_DISP  = CNT_W'(Timing1080pH.disp),
    parameter logic [CNT_W-1:0] D_H_FRONT = CNT_W'(Timing1080pH.front),
    parameter logic [CNT_W-1:0] D_V_SYNC  = CNT_W'(Timing1080pV.sync),
    parameter logic [CNT_W-1:0] D_V_BACK  = CNT_W'(Timing1080pV.back),
    parameter logic [CNT_W-1:0] D_V_DISP  = CNT_W'(Timing1080pV.disp),
    parameter logic [CNT_W-1:0] D_V_FRONT = CNT_W'(Timing1080pV.front)
) (
    input  logic              pixel_clk,
    input  logic              sys_rst,
    input  logic [CNT_W-1:0]  cfg_h_sync,
    input  logic [CNT_W-1:0]  cfg_h_back,
    input  logic [CNT_W-1:0]  cfg_h_disp,
    input  logic [CNT_W-1:0]  cfg_h_front,
    input  logic [CNT_W-1:0]  cfg_v_sync,
    input  logic [CNT_W-1:0]  cfg_v_back,
    input  logic [CNT_W-1:0]  cfg_v_disp,
    input  logic [CNT_W-1:0]  cfg_v_front,
    input  logic              cfg_valid,
    output logic              cfg_err,
    output logic              cfg_busy,
    input  logic              tpg_en,
    input  logic [3*CW-1:0]   pixel_data,
    output logic              data_req,
    output logic [CNT_W-1:0]  pixel_xpos,
    output logic [CNT_W-1:0]  pixel_ypos,
    output logic              video_hs,
    output logic              video_vs,
    output logic              video_de,
    output logic [3*CW-1:0]   video_rgb,
    output logic              frame_start,
    output logic              line_start
);

    localparam int unsigned CfgW = 8 * CNT_W;
    localparam logic [CfgW-1:0] RstWord = {D_H_SYNC, D_H_BACK, D_H_DISP, D_H_FRONT,
                                           D_V_SYNC, D_V_BACK, D_V_DISP, D_V_FRONT};

    function automatic logic [CNT_W-1:0] fld(input logic [CfgW-1:0] w, input int unsigned idx);
        return w[CfgW-1-idx*CNT_W -: CNT_W];
    endfunction

    logic [CfgW-1:0] act_q, act_d, stg_q, stg_d, cfg_word;
    logic            busy_q, busy_d, err_q, err_d, cfg_ok;
    logic [CNT_W:0]  cfg_lead_room;

    assign cfg_word = {cfg_h_sync, cfg_h_back, cfg_h_disp, cfg_h_front,
                       cfg_v_sync, cfg_v_back, cfg_v_disp, cfg_v_front};

    // The request window must not start before the line does.
    assign cfg_lead_room = {1'b0, cfg_h_sync} + {1'b0, cfg_h_back};
    assign cfg_ok = (cfg_h_disp != '0) && (cfg_v_disp != '0) && (cfg_h_sync != '0) &&
                    (cfg_v_sync != '0) && (cfg_lead_room >= (CNT_W+1)'(REQ_LEAD));

    logic [CNT_W-1:0] h_cnt, v_cnt, h_pos, v_pos, h_disp;
    logic             h_term, v_term, h_sync, v_sync, h_act, v_act, h_req, v_req;
    logic             frame_end;

    assign h_disp    = fld(act_q, FldHDisp);
    assign frame_end = h_term && v_term;

    video_axis_cnt #(.CNT_W(CNT_W), .LEAD(REQ_LEAD)) u_h_cnt (
        .clk_i   (pixel_clk),
        .rst_i   (sys_rst),
        .en_i    (1'b1),
        .sync_i  (fld(act_q, FldHSync)),
        .back_i  (fld(act_q, FldHBack)),
        .disp_i  (h_disp),
        .front_i (fld(act_q, FldHFront)),
        .cnt_o   (h_cnt),
        .term_o  (h_term),
        .sync_o  (h_sync),
        .act_o   (h_act),
        .req_o   (h_req),
        .pos_o   (h_pos)
    );

    video_axis_cnt #(.CNT_W(CNT_W), .LEAD(0)) u_v_cnt (
        .clk_i   (pixel_clk),
        .rst_i   (sys_rst),
        .en_i    (h_term),
        .sync_i  (fld(act_q, FldVSync)),
        .back_i  (fld(act_q, FldVBack)),
        .disp_i  (fld(act_q, FldVDisp)),
        .front_i (fld(act_q, FldVFront)),
        .cnt_o   (v_cnt),
        .term_o  (v_term),
        .sync_o  (v_sync),
        .act_o   (v_act),
        .req_o   (v_req),
        .pos_o   (v_pos)
    );

    // Staging: apply pending timing at frame end, then accept any new legal strobe.
    always_comb begin
        act_d  = act_q;
        stg_d  = stg_q;
        busy_d = busy_q;
        err_d  = cfg_valid && !cfg_ok;
        if (frame_end && busy_q) begin
            act_d  = stg_q;
            busy_d = 1'b0;
        end
        if (cfg_valid && cfg_ok) begin
            stg_d  = cfg_word;
            busy_d = 1'b1;
        end
    end

    // Active and staged timing registers.
    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            act_q  <= RstWord;
            stg_q  <= '0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            act_q  <= act_d;
            stg_q  <= stg_d;
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    logic             hs_d, vs_d, de_d, req_d, fs_d, ls_d;
    logic             hs_q, vs_q, de_q, req_q, fs_q, ls_q;
    logic [CNT_W-1:0] xpos_d, ypos_d, xpos_q, ypos_q;
    logic [3*CW-1:0]  rgb_d, rgb_q, pix_sel;

`ifdef VIDEO_TPG_EN
    logic [2:0]       bar_idx_q, bar_idx_d;
    logic [CNT_W-1:0] bar_run_q, bar_run_d, bar_w;
    logic [2:0]       bar_mask;

    assign bar_w    = h_disp >> 3;
    assign bar_mask = BarRgb[bar_idx_q];

    // Track bar index across the active part of each line; last bar absorbs the remainder.
    always_comb begin
        bar_idx_d = '0;
        bar_run_d = '0;
        if (h_act) begin
            bar_idx_d = bar_idx_q;
            bar_run_d = bar_run_q + 1'b1;
            if ((bar_run_q == bar_w - 1'b1) && (bar_idx_q != 3'd7)) begin
                bar_idx_d = bar_idx_q + 1'b1;
                bar_run_d = '0;
            end
        end
    end

    // Bar position registers.
    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            bar_idx_q <= '0;
            bar_run_q <= '0;
        end else begin
            bar_idx_q <= bar_idx_d;
            bar_run_q <= bar_run_d;
        end
    end

    assign pix_sel = tpg_en ? {{CW{bar_mask[2]}}, {CW{bar_mask[1]}}, {CW{bar_mask[0]}}}
                            : pixel_data;
`else
    logic unused_tpg;
    assign unused_tpg = tpg_en;
    assign pix_sel    = pixel_data;
`endif

    // Output next-state, decoded from the current counter position.
    always_comb begin
        hs_d   = h_sync ? HS_POL : ~HS_POL;
        vs_d   = v_sync ? VS_POL : ~VS_POL;
        req_d  = h_req && v_req;
        xpos_d = req_d ? h_pos : '0;
        ypos_d = req_d ? v_pos : '0;
        de_d   = h_act && v_act;
        rgb_d  = de_d ? pix_sel : '0;
        fs_d   = (h_cnt == '0) && (v_cnt == '0);
        ls_d   = (h_cnt == '0);
    end

    // Output register stage.
    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            hs_q   <= ~HS_POL;
            vs_q   <= ~VS_POL;
            req_q  <= 1'b0;
            xpos_q <= '0;
            ypos_q <= '0;
            de_q   <= 1'b0;
            rgb_q  <= '0;
            fs_q   <= 1'b0;
            ls_q   <= 1'b0;
        end else begin
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            req_q  <= req_d;
            xpos_q <= xpos_d;
            ypos_q <= ypos_d;
            de_q   <= de_d;
            rgb_q  <= rgb_d;
            fs_q   <= fs_d;
            ls_q   <= ls_d;
        end
    end

    assign video_hs    = hs_q;
    assign video_vs    = vs_q;
    assign data_req    = req_q;
    assign pixel_xpos  = xpos_q;
    assign pixel_ypos  = ypos_q;
    assign video_de    = de_q;
    assign video_rgb   = rgb_q;
    assign frame_start = fs_q;
    assign line_start  = ls_q;
    assign cfg_err     = err_q;
    assign cfg_busy    = busy_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen in a small mode (H 2/2/8/2, V 1/1/4/1, REQ_LEAD=2).
// A cycle model predicts control outputs; requested pixels are queued and
// checked against video_rgb when video_de is expected.
module tb_video_timing_gen;

    localparam int CW    = 8;
    localparam int CNT_W = 12;
    localparam int L     = 2;

    logic              pixel_clk = 1'b0;
    logic              sys_rst   = 1'b1;
    logic [CNT_W-1:0]  cfg_h_sync = '0, cfg_h_back = '0, cfg_h_disp = '0, cfg_h_front = '0;
    logic [CNT_W-1:0]  cfg_v_sync = '0, cfg_v_back = '0, cfg_v_disp = '0, cfg_v_front = '0;
    logic              cfg_valid = 1'b0;
    logic              tpg_en = 1'b0;
    logic [3*CW-1:0]   pixel_data = '0;
    logic              cfg_err, cfg_busy, data_req, video_hs, video_vs, video_de;
    logic              frame_start, line_start;
    logic [CNT_W-1:0]  pixel_xpos, pixel_ypos;
    logic [3*CW-1:0]   video_rgb;

    always #5 pixel_clk = ~pixel_clk;

    video_timing_gen #(
        .CW(CW), .CNT_W(CNT_W), .REQ_LEAD(L), .HS_POL(1'b0), .VS_POL(1'b0),
        .D_H_SYNC(12'd2), .D_H_BACK(12'd2), .D_H_DISP(12'd8), .D_H_FRONT(12'd2),
        .D_V_SYNC(12'd1), .D_V_BACK(12'd1), .D_V_DISP(12'd4), .D_V_FRONT(12'd1)
    ) dut (
        .pixel_clk   (pixel_clk),
        .sys_rst     (sys_rst),
        .cfg_h_sync  (cfg_h_sync),
        .cfg_h_back  (cfg_h_back),
        .cfg_h_disp  (cfg_h_disp),
        .cfg_h_front (cfg_h_front),
        .cfg_v_sync  (cfg_v_sync),
        .cfg_v_back  (cfg_v_back),
        .cfg_v_disp  (cfg_v_disp),
        .cfg_v_front (cfg_v_front),
        .cfg_valid   (cfg_valid),
        .cfg_err     (cfg_err),
        .cfg_busy    (cfg_busy),
        .tpg_en      (tpg_en),
        .pixel_data  (pixel_data),
        .data_req    (data_req),
        .pixel_xpos  (pixel_xpos),
        .pixel_ypos  (pixel_ypos),
        .video_hs    (video_hs),
        .video_vs    (video_vs),
        .video_de    (video_de),
        .video_rgb   (video_rgb),
        .frame_start (frame_start),
        .line_start  (line_start)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    bit trk = 1'b0;
    int first_de = -1;
    int first_req = -1;
    int de_frame0 = 0;
    int fs_cyc[$];

    // Model state: counter position of the current cycle and timing records.
    int mh = 0, mv = 0;
    int tm[8];
    int stg[8];
    bit pend = 1'b0;
    int dflt[8] = '{2, 2, 8, 2, 1, 1, 4, 1};

    logic [3*CW-1:0] sb_q[$];
    logic [3*CW-1:0] src_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [23:0] bar_colour(input int x, input int hd);
        int w;
        int b;
        w = hd >> 3;
        b = (w == 0) ? 0 : x / w;
        if (b > 7) b = 7;
        case (b)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic bit at_frame_end();
        return (mh == tm[0] + tm[1] + tm[2] + tm[3] - 1) && (mv == tm[4] + tm[5] + tm[6] + tm[7] - 1);
    endfunction

    // One clock: predict outputs from current inputs and model, then compare.
    task automatic step();
        logic hs, vs, de, req, fs, ls, err, vact;
        int xp, yp, ht, vt, hd_now;
        bit legal;
        int c[8];
        logic [31:0] exp_v, obs_v;
        logic [23:0] code;
        c = '{int'(cfg_h_sync), int'(cfg_h_back), int'(cfg_h_disp), int'(cfg_h_front),
              int'(cfg_v_sync), int'(cfg_v_back), int'(cfg_v_disp), int'(cfg_v_front)};
        hd_now = tm[2];
        if (sys_rst) begin
            hs = 1'b1; vs = 1'b1; de = 1'b0; req = 1'b0; fs = 1'b0; ls = 1'b0; err = 1'b0;
            xp = 0; yp = 0;
            mh = 0; mv = 0; tm = dflt; pend = 1'b0;
            sb_q.delete(); src_q.delete();
        end else begin
            ht   = tm[0] + tm[1] + tm[2] + tm[3];
            vt   = tm[4] + tm[5] + tm[6] + tm[7];
            hs   = (mh < tm[0]) ? 1'b0 : 1'b1;
            vs   = (mv < tm[4]) ? 1'b0 : 1'b1;
            vact = (mv >= tm[4] + tm[5]) && (mv < tm[4] + tm[5] + tm[6]);
            de   = (mh >= tm[0] + tm[1]) && (mh < tm[0] + tm[1] + tm[2]) && vact;
            req  = (mh >= tm[0] + tm[1] - L) && (mh < tm[0] + tm[1] + tm[2] - L) && vact;
            xp   = req ? mh - (tm[0] + tm[1] - L) : 0;
            yp   = req ? mv - (tm[4] + tm[5]) : 0;
            fs   = (mh == 0) && (mv == 0);
            ls   = (mh == 0);
            legal = (c[2] != 0) && (c[6] != 0) && (c[0] != 0) && (c[4] != 0) && (c[0] + c[1] >= L);
            err  = cfg_valid && !legal;
            if ((mh == ht - 1) && (mv == vt - 1) && pend) begin
                tm = stg;
                pend = 1'b0;
            end
            if (cfg_valid && legal) begin
                stg = c;
                pend = 1'b1;
            end
            if (mh == ht - 1) begin
                mh = 0;
                mv = (mv == vt - 1) ? 0 : mv + 1;
            end else begin
                mh++;
            end
        end
        exp_v = {hs, vs, de, req, 12'(xp), 12'(yp), fs, ls, err, pend};

        @(posedge pixel_clk);
        #1;
        cyc++;
        obs_v = {video_hs, video_vs, video_de, data_req, pixel_xpos, pixel_ypos,
                 frame_start, line_start, cfg_err, cfg_busy};
        check("ctrl", obs_v, exp_v);
        if (de) begin
            check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) check("rgb", 32'(video_rgb), 32'(sb_q.pop_front()));
        end else begin
            check("rgb_idle", 32'(video_rgb), 32'd0);
        end

        code = 24'(xp + (yp << 8));
        if (req) begin
`ifdef VIDEO_TPG_EN
            if (tpg_en) sb_q.push_back(bar_colour(xp, hd_now));
            else sb_q.push_back(code);
`else
            sb_q.push_back(code);
`endif
        end
        // Source answers each request REQ_LEAD-1 cycles later.
        src_q.push_back(req ? code : 24'hA5A5A5);
        if (src_q.size() >= L) pixel_data = src_q.pop_front();

        if (trk) begin
            if (video_de && first_de < 0) first_de = cyc;
            if (data_req && first_req < 0) first_req = cyc;
            if (video_de && cyc <= 98) de_frame0++;
            if (frame_start) fs_cyc.push_back(cyc);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic apply_cfg(input int hs, input int hb, input int hd, input int hf,
                             input int vs, input int vb, input int vd, input int vf);
        cfg_h_sync = 12'(hs); cfg_h_back = 12'(hb); cfg_h_disp = 12'(hd); cfg_h_front = 12'(hf);
        cfg_v_sync = 12'(vs); cfg_v_back = 12'(vb); cfg_v_disp = 12'(vd); cfg_v_front = 12'(vf);
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        tm = dflt;
        stg = dflt;

        // Reset values.
        sys_rst = 1'b1;
        run(3);

        // First frame of the small mode.
        sys_rst = 1'b0;
        cyc = 0;
        trk = 1'b1;
        run(99);
        check("first_req_cyc", 32'(first_req), 32'd31);
        check("first_de_cyc", 32'(first_de), 32'd33);
        check("de_cycles_frame0", 32'(de_frame0), 32'd32);
        check("fs_count", 32'(fs_cyc.size()), 32'd2);
        if (fs_cyc.size() >= 2) check("fs_period", 32'(fs_cyc[1] - fs_cyc[0]), 32'd98);

        // Mid-frame reload to 4-pixel lines.
        run(30);
        apply_cfg(2, 2, 4, 2, 1, 1, 4, 1);
        fs_cyc.delete();
        run(200);
        check("fs_count_reload", 32'(fs_cyc.size() >= 2), 32'd1);
        if (fs_cyc.size() >= 2)
            check("fs_period_reload", 32'(fs_cyc[fs_cyc.size()-1] - fs_cyc[fs_cyc.size()-2]), 32'd70);

        // Illegal configurations: h_disp, v_disp, h_sync, v_sync zero, lead too large.
        apply_cfg(2, 2, 0, 2, 1, 1, 4, 1);
        run(3);
        apply_cfg(2, 2, 4, 2, 1, 1, 0, 1);
        apply_cfg(0, 3, 4, 2, 1, 1, 4, 1);
        apply_cfg(2, 2, 4, 2, 0, 1, 4, 1);
        apply_cfg(1, 0, 4, 2, 1, 1, 4, 1);
        run(20);

        // Two strobes before the boundary: the second one wins.
        apply_cfg(2, 2, 6, 2, 1, 1, 4, 1);
        run(5);
        apply_cfg(3, 2, 8, 2, 2, 1, 3, 1);
        run(250);

        // Strobe on the last cycle of a frame is applied one frame later.
        for (int i = 0; i < 1000 && !at_frame_end(); i++) step();
        check("frame_end_reached", 32'(at_frame_end()), 32'd1);
        apply_cfg(2, 2, 8, 2, 1, 1, 4, 1);
        run(300);

        // Reset mid-line with a pending configuration.
        run(10);
        apply_cfg(2, 2, 4, 2, 1, 1, 4, 1);
        run(5);
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        run(200);

`ifdef VIDEO_TPG_EN
        // Colour bars over a 16-pixel line.
        tpg_en = 1'b1;
        apply_cfg(2, 2, 16, 2, 1, 1, 4, 1);
        run(400);
        tpg_en = 1'b0;
        run(20);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Parametrised raster timing generator and pixel-request front end for the video output path. It is the successor to the fixed 1080p driver:
- runtime-reloadable timing, applied glitch-free at frame boundaries;
- configurable sync polarity and colour width;
- data_req lead time matched to the latency of the upstream frame-buffer read;
- fully registered outputs.

It sits between the DDR read/stitch pipeline (source of pixel_data) and the HDMI/DVI encoder.

Parameters:
- CW, 8: bits per colour channel; video_rgb is 3*CW wide.
- CNT_W, 12: width of counters, coordinates and timing config fields.
- REQ_LEAD, 1: cycles data_req leads video_de. Legal range 1..4.
- HS_POL, 1'b0: active level of video_hs.
- VS_POL, 1'b0: active level of video_vs.
- D_H_SYNC/D_H_BACK/D_H_DISP/D_H_FRONT, 44/148/1920/88: reset horizontal timing.
- D_V_SYNC/D_V_BACK/D_V_DISP/D_V_FRONT, 5/36/1080/4: reset vertical timing.

Ports:
- pixel_clk  in  1  pixel clock; the only clock.
- sys_rst  in  1  synchronous, active-high reset.
- cfg_h_sync, cfg_h_back, cfg_h_disp, cfg_h_front  in  CNT_W each  new horizontal timing.
- cfg_v_sync, cfg_v_back, cfg_v_disp, cfg_v_front  in  CNT_W each  new vertical timing.
- cfg_valid  in  1  single-cycle strobe; captures all cfg_* fields.
- cfg_err  out  1  pulse: rejected configuration.
- cfg_busy  out  1  a staged configuration is waiting for the frame boundary.
- tpg_en  in  1  test-pattern select (used only with the optional feature).
- pixel_data  in  3*CW  pixel returned by the source.
- data_req  out  1  pixel request.
- pixel_xpos, pixel_ypos  out  CNT_W each  0-based coordinates of the requested pixel.
- video_hs, video_vs, video_de  out  1 each  sync and data enable.
- video_rgb  out  3*CW  pixel output; 0 when video_de is low.
- frame_start  out  1  one-cycle pulse at the first cycle of each frame.
- line_start  out  1  one-cycle pulse at the first cycle of each line.

Behaviour:
- Reset:
  - counters = 0; active timing = D_* parameters; staging cleared.
  - video_hs = ~HS_POL, video_vs = ~VS_POL.
  - de, rgb, req, xpos, ypos, frame_start, line_start, cfg_err, cfg_busy all = 0.
- Totals: h_total = sync+back+disp+front, computed in CNT_W+1 bits; v_total likewise.
- cnt_h runs 0..h_total-1. cnt_v increments when cnt_h = h_total-1 and wraps at v_total-1.
- Every output is a register driven from the current counter state. Counter value t therefore appears on the outputs at cycle t+1, and this 1-cycle offset is uniform across all outputs.
- hs is active while cnt_h < h_sync. vs is active while cnt_v < v_sync.
- Active region: cnt_h in [h_sync+h_back, h_sync+h_back+h_disp) and cnt_v in [v_sync+v_back, v_sync+v_back+v_disp).
- data_req:
  - Asserts over the active window shifted REQ_LEAD cycles earlier in cnt_h.
  - pixel_xpos counts 0..h_disp-1 while data_req is high.
  - pixel_ypos = line index within the active region.
  - Both coordinates are 0 when data_req is low.
- Data timing: if data_req is high at cycle t for pixel x, the source must drive that pixel on pixel_data at cycle t+REQ_LEAD-1. video_de is high and video_rgb equals that pixel at cycle t+REQ_LEAD.
- de/rgb pipeline: video_de and video_rgb are delayed internally so they align with hs/vs.
- REQ_LEAD constraint: REQ_LEAD <= h_sync+h_back. A configuration violating this is illegal.
- Config staging:
  - cfg_valid copies cfg_* into staging and sets cfg_busy.
  - Staging is applied on the last cycle of the frame (cnt_h = h_total-1 and cnt_v = v_total-1); counters then wrap to 0 under the new timing and cfg_busy clears.
  - A cfg_valid in that same last cycle is staged but not applied until the next frame end.
  - A second cfg_valid before the boundary overwrites staging (last one wins).
- Rejection: if cfg_h_disp = 0, cfg_v_disp = 0, cfg_h_sync = 0, cfg_v_sync = 0, or cfg_h_sync+cfg_h_back < REQ_LEAD:
  - staging is unchanged;
  - cfg_err pulses for 1 cycle;
  - cfg_busy keeps its prior value.
- frame_start = registered (cnt_h = 0 and cnt_v = 0). line_start = registered (cnt_h = 0).
- Reset mid-frame: all state returns to the reset values above on the next edge; any pending staged configuration is discarded.

Optional Feature:
- Macro: VIDEO_TPG_EN.
- Defined: when tpg_en = 1, video_rgb ignores pixel_data and shows 8 vertical colour bars.
  - Bar index = x / (h_disp >> 3), saturated at 7.
  - Colours in order: white, yellow, cyan, green, magenta, red, blue, black, using full-scale channels.
  - Bars share the same de/rgb timing as pixel data.
  - data_req still toggles.
- Undefined: tpg_en is ignored and no TPG logic is built.

Decomposition:
- Shared package video_timing_pkg:
  - struct video_timing_t holding sync/back/disp/front for one axis;
  - 1080p60 and 720p60 constant instances;
  - colour-bar constant table.
- Sub-module video_axis_cnt, instantiated once for H and once for V: counter, terminal flag, sync/active/request compares.
- Staging registers and output register stage stay in the top-level module.

Test Plan:
- Small mode H 2/2/8/2 (h_total 14), V 1/1/4/1 (v_total 7), REQ_LEAD=2, loaded at reset:
  - first de at cnt_h=4 +1 cycle offset;
  - data_req rises 2 cycles earlier;
  - 8 de cycles per line, 4 active lines;
  - frame_start period 98 cycles.
- Source returns xpos+(ypos<<8) with latency REQ_LEAD-1: every video_rgb sample equals its expected coordinate code; rgb = 0 outside de.
- Reload to H 2/2/4/2 mid-frame:
  - cfg_busy=1 until frame end;
  - previous frame unchanged;
  - next frame has 4-pixel lines with h_total 10.
- Illegal cfg_h_disp=0 → cfg_err pulses once, cfg_busy stays 0, timing unchanged. cfg_valid on the last frame cycle → applied one frame later.
- Assert sys_rst mid-line with a config pending → next cycle shows reset values, staging is dropped, and timing restarts from D_*.
- VIDEO_TPG_EN defined, tpg_en=1, h_disp=16: rgb = FFFFFF for x=0..1, FFFF00 for x=2..3, …, 000000 for x=14..15.
